// File: rtl/exp_add_arbiter.sv
// exp_add_arbiter
// Two requesters share one exponent adder. Requester 0 is the normalization
// stage and requester 1 is the rounding/post-processing stage. When both
// request at the same time, they are served in turn (round-robin).
// The winner's operands are captured on the grant edge. The add runs on the
// next edge, and the result comes back tagged with the winner's ID.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   req0_i, a0_i, b0_i  requester 0: level request, P-bit exponent, 5-bit adjust
//   req1_i, a1_i, b1_i  requester 1: level request, P-bit exponent, 5-bit adjust
//   ack0_o, ack1_o      one-cycle pulse: that requester's operands were captured
//   busy_o              FSM not idle
//   done_o              one-cycle pulse: y_o / ovf_o / done_id_o are valid
//   done_id_o           requester that owns the current result
//   y_o, ovf_o          sum[P-1:0] and carry out sum[P]
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no operation in flight; grant on any request
// CALC  | operands registered, ack pulse out; add happens on this edge
// DONE  | result valid (done pulse); may accept the next request directly
module exp_add_arbiter #(
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_i,
    input  logic [P-1:0] a0_i,
    input  logic [4:0]   b0_i,
    input  logic         req1_i,
    input  logic [P-1:0] a1_i,
    input  logic [4:0]   b1_i,
    output logic         ack0_o,
    output logic         ack1_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         done_id_o,
    output logic [P-1:0] y_o,
    output logic         ovf_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       state;
    logic [P-1:0] opa;
    logic [4:0]   opb;
    logic         id;
    logic         last_id;

    logic         winner;
    logic [P:0]   sum;

    // A lone requester always wins. Under contention, the one not served last wins.
    assign winner = (req0_i & req1_i) ? ~last_id : req1_i;

    // Zero-extended (P+1)-bit add; the top bit is the overflow.
    assign sum = {1'b0, opa} + {{(P-4){1'b0}}, opb};

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            id        <= 1'b0;
            last_id   <= 1'b1;
            ack0_o    <= 1'b0;
            ack1_o    <= 1'b0;
            done_o    <= 1'b0;
            done_id_o <= 1'b0;
            y_o       <= '0;
            ovf_o     <= 1'b0;
        end else begin
            ack0_o <= 1'b0;
            ack1_o <= 1'b0;
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (req0_i | req1_i) begin
                        state   <= CALC;
                        last_id <= winner;
                        id      <= winner;
                        opa     <= winner ? a1_i : a0_i;
                        opb     <= winner ? b1_i : b0_i;
                        ack0_o  <= ~winner;
                        ack1_o  <= winner;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    y_o       <= sum[P-1:0];
                    ovf_o     <= sum[P];
                    done_id_o <= id;
                    done_o    <= 1'b1;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_add_arbiter.sv
module tb_exp_add_arbiter;

    localparam int P = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_i, req1_i;
    logic [P-1:0] a0_i, a1_i;
    logic [4:0]   b0_i, b1_i;
    logic         ack0_o, ack1_o, busy_o, done_o, done_id_o, ovf_o;
    logic [P-1:0] y_o;

    int errors = 0;
    int checks = 0;

    // Control outputs as one vector: {ack0, ack1, busy, done}
    logic [3:0] ctl;
    assign ctl = {ack0_o, ack1_o, busy_o, done_o};

    exp_add_arbiter #(.P(P)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0_i), .a0_i(a0_i), .b0_i(b0_i),
        .req1_i(req1_i), .a1_i(a1_i), .b1_i(b1_i),
        .ack0_o(ack0_o), .ack1_o(ack1_o), .busy_o(busy_o),
        .done_o(done_o), .done_id_o(done_id_o), .y_o(y_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (ctl !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl got=%b exp=0000", ctl);
        end
        checks++;
        if ({y_o, ovf_o, done_id_o} !== 10'd0) begin
            errors++; $display("FAIL reset_data got y=%h ovf=%b id=%b exp all 0", y_o, ovf_o, done_id_o);
        end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ctl, y_o, ovf_o, done_id_o} !== 14'd0) begin
            errors++; $display("FAIL reset_idle got ctl=%b y=%h ovf=%b id=%b exp all 0", ctl, y_o, ovf_o, done_id_o);
        end
    endtask

    task automatic test_single();
        req0_i = 1'b1; a0_i = 8'd120; b0_i = 5'd7;
        tick();
        checks++;
        if (ctl !== 4'b1010) begin
            errors++; $display("FAIL single_ack got=%b exp=1010", ctl);
        end
        req0_i = 1'b0; a0_i = 8'd0; b0_i = 5'd0;
        tick();
        checks++;
        if (ctl !== 4'b0011) begin
            errors++; $display("FAIL single_done_ctl got=%b exp=0011", ctl);
        end
        checks++;
        if ({y_o, ovf_o, done_id_o} !== {8'd127, 1'b0, 1'b0}) begin
            errors++; $display("FAIL single_result got y=%0d ovf=%b id=%b exp y=127 ovf=0 id=0", y_o, ovf_o, done_id_o);
        end
        tick();
        checks++;
        if (ctl !== 4'b0000 || y_o !== 8'd127) begin
            errors++; $display("FAIL single_hold got ctl=%b y=%0d exp ctl=0000 y=127", ctl, y_o);
        end
    endtask

    task automatic test_overflow();
        req1_i = 1'b1; a1_i = 8'hFE; b1_i = 5'd5;
        tick();
        checks++;
        if (ctl !== 4'b0110) begin
            errors++; $display("FAIL ovf1_ack got=%b exp=0110", ctl);
        end
        req1_i = 1'b0;
        tick();
        checks++;
        if ({ctl, y_o, ovf_o, done_id_o} !== {4'b0011, 8'h03, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ovf1_result got ctl=%b y=%h ovf=%b id=%b exp ctl=0011 y=03 ovf=1 id=1", ctl, y_o, ovf_o, done_id_o);
        end
        tick();
        req0_i = 1'b1; a0_i = 8'hFF; b0_i = 5'd31;
        tick();
        req0_i = 1'b0;
        tick();
        checks++;
        if ({ctl, y_o, ovf_o, done_id_o} !== {4'b0011, 8'h1E, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ovf_max_result got ctl=%b y=%h ovf=%b id=%b exp ctl=0011 y=1e ovf=1 id=0", ctl, y_o, ovf_o, done_id_o);
        end
        tick();
        req0_i = 1'b1; a0_i = 8'd0; b0_i = 5'd0;
        tick();
        req0_i = 1'b0;
        tick();
        checks++;
        if ({ctl, y_o, ovf_o} !== {4'b0011, 8'h00, 1'b0}) begin
            errors++; $display("FAIL zero_result got ctl=%b y=%h ovf=%b exp ctl=0011 y=00 ovf=0", ctl, y_o, ovf_o);
        end
        tick();
    endtask

    task automatic test_contention();
        logic       eid;
        logic [7:0] ey;
        do_reset();
        req0_i = 1'b1; a0_i = 8'd10; b0_i = 5'd1;
        req1_i = 1'b1; a1_i = 8'd20; b1_i = 5'd2;
        for (int n = 0; n < 4; n++) begin
            eid = n[0];
            ey  = eid ? 8'd22 : 8'd11;
            tick();
            checks++;
            if (ctl !== {~eid, eid, 2'b10}) begin
                errors++; $display("FAIL cont_ack n=%0d got=%b exp=%b", n, ctl, {~eid, eid, 2'b10});
            end
            tick();
            checks++;
            if ({ctl, y_o, done_id_o} !== {4'b0011, ey, eid}) begin
                errors++; $display("FAIL cont_done n=%0d got ctl=%b y=%0d id=%b exp ctl=0011 y=%0d id=%b", n, ctl, y_o, done_id_o, ey, eid);
            end
        end
        req0_i = 1'b0; req1_i = 1'b0;
        tick();
        checks++;
        if (ctl !== 4'b0000) begin
            errors++; $display("FAIL cont_idle got=%b exp=0000", ctl);
        end
    endtask

    task automatic test_back_to_back();
        req0_i = 1'b1; a0_i = 8'd50; b0_i = 5'd3;
        tick();
        checks++;
        if (ctl !== 4'b1010) begin
            errors++; $display("FAIL b2b_ack0 got=%b exp=1010", ctl);
        end
        req0_i = 1'b0;
        tick();
        checks++;
        if ({ctl, y_o, done_id_o} !== {4'b0011, 8'd53, 1'b0}) begin
            errors++; $display("FAIL b2b_done0 got ctl=%b y=%0d id=%b exp ctl=0011 y=53 id=0", ctl, y_o, done_id_o);
        end
        req1_i = 1'b1; a1_i = 8'd100; b1_i = 5'd10;
        tick();
        checks++;
        if (ctl !== 4'b0110) begin
            errors++; $display("FAIL b2b_ack1 got=%b exp=0110", ctl);
        end
        req1_i = 1'b0; a1_i = 8'd0;
        tick();
        checks++;
        if ({ctl, y_o, done_id_o} !== {4'b0011, 8'd110, 1'b1}) begin
            errors++; $display("FAIL b2b_done1 got ctl=%b y=%0d id=%b exp ctl=0011 y=110 id=1", ctl, y_o, done_id_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        req0_i = 1'b1; a0_i = 8'd60; b0_i = 5'd2;
        tick();
        req0_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b0000) begin
            errors++; $display("FAIL mid_async got=%b exp=0000", ctl);
        end
        checks++;
        if ({y_o, ovf_o, done_id_o} !== 10'd0) begin
            errors++; $display("FAIL mid_data got y=%h ovf=%b id=%b exp all 0", y_o, ovf_o, done_id_o);
        end
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            tick();
            if (done_o) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL mid_nodone got done_seen=%b busy=%b exp 0 0", saw_done, busy_o);
        end
        // Both request: with last_id back at 1, requester 0 must win.
        req0_i = 1'b1; a0_i = 8'd3; b0_i = 5'd4;
        req1_i = 1'b1; a1_i = 8'd9; b1_i = 5'd9;
        tick();
        checks++;
        if (ctl !== 4'b1010) begin
            errors++; $display("FAIL mid_grant got=%b exp=1010", ctl);
        end
        req0_i = 1'b0; req1_i = 1'b0;
        tick();
        checks++;
        if ({ctl, y_o, ovf_o, done_id_o} !== {4'b0011, 8'd7, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mid_result got ctl=%b y=%0d ovf=%b id=%b exp ctl=0011 y=7 ovf=0 id=0", ctl, y_o, ovf_o, done_id_o);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req0_i = 1'b0; a0_i = '0; b0_i = '0;
        req1_i = 1'b0; a1_i = '0; b1_i = '0;
        test_reset();
        test_single();
        test_overflow();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
